rcv_capture_buffer: RTL

Parametrised receive-path capture buffer, successor to the single enabled D flip-flop stage in the rcvbuffer chain. It continuously records `WIDTH`-bit receive samples into a `DEPTH`-entry circular memory on clock-enabled cycles. On a trigger it records a programmable number of post-trigger samples, then freezes. It then reads the full window out, oldest sample first, over a valid/ready stream to the downstream consumer.

---
 rtl/rcvbuffer_pkg.sv | 16 +
 rtl/rcv_buf_ram.sv | 28 ++
 rtl/rcv_capture_buffer.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/rcvbuffer_pkg.sv
`default_nettype none
// =====================================================================
// rcvbuffer_pkg -- shared types for the receive capture buffer
// Rev 1.0
// =====================================================================
package rcvbuffer_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ARMED   = 2'd1,
      POST    = 2'd2,
      READOUT = 2'd3
   } cap_state_t;

endpackage
`default_nettype wire

// File: rtl/rcv_buf_ram.sv
`default_nettype none
// =====================================================================
// rcv_buf_ram -- WIDTH x DEPTH simple dual-port RAM, synchronous read
// Rev 1.0
// =====================================================================
module rcv_buf_ram #(
   parameter int WIDTH  = 16,
   parameter int DEPTH  = 64,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              i_we,
   input  logic [ADDR_W-1:0] i_waddr,
   input  logic [WIDTH-1:0]  i_wdata,
   input  logic [ADDR_W-1:0] i_raddr,
   output logic [WIDTH-1:0]  o_rdata
);

   logic [WIDTH-1:0] r_mem [DEPTH];

   always_ff @(posedge clk) begin
      if (i_we)
         r_mem[i_waddr] <= i_wdata;
      o_rdata <= r_mem[i_raddr];
   end

endmodule
`default_nettype wire

// File: rtl/rcv_capture_buffer.sv
`default_nettype none
// =====================================================================
// rcv_capture_buffer -- circular pre/post-trigger capture, streamed readout
// Rev 1.0
// =====================================================================
module rcv_capture_buffer
   import rcvbuffer_pkg::*;
#(
   parameter int WIDTH  = 16,
   parameter int DEPTH  = 64,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [WIDTH-1:0]  in,
   input  logic              clken,
   input  logic              arm,
   input  logic              trig,
   input  logic [ADDR_W:0]   post_count,
   output logic [WIDTH-1:0]  rd_data,
   output logic              rd_valid,
   output logic              rd_last,
   input  logic              rd_ready,
   output logic              busy,
   output logic              done
);

   localparam logic [ADDR_W:0]   c_depth   = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0]   c_cnt_one = (ADDR_W+1)'(1);
   localparam logic [ADDR_W-1:0] c_ptr_one = ADDR_W'(1);

   cap_state_t        r_state;
   logic [ADDR_W-1:0] r_wr_ptr;
   logic [ADDR_W:0]   r_fill;
   logic [ADDR_W:0]   r_remaining;
   logic [ADDR_W:0]   r_rd_cnt;
   logic              r_q_vld;
   logic              r_q_last;
   logic              r_skid_vld;
   logic              r_skid_last;
   logic [WIDTH-1:0]  r_skid_data;

   logic [ADDR_W:0]   w_pc;
   logic              w_accept;
   logic              w_we;
   logic              w_hs;
   logic              w_out_free;
   logic              w_skid_nxt;
   logic              w_issue;
   logic [ADDR_W-1:0] w_rd_addr;
   logic [WIDTH-1:0]  w_q;

   assign w_pc       = (post_count > c_depth) ? c_depth : post_count;
   assign w_accept   = (r_state == ARMED) && trig && (r_fill >= (c_depth - w_pc));
   assign w_we       = clken && ((r_state == ARMED) || (r_state == POST));
   assign w_hs       = rd_valid && rd_ready;
   assign w_out_free = !rd_valid || rd_ready;
   // The frozen write pointer addresses the oldest entry of the window.
   assign w_rd_addr  = r_wr_ptr + r_rd_cnt[ADDR_W-1:0];

   // A read is launched only if the skid slot will be free when its data lands,
   // so the word always has somewhere to go even if the consumer stalls.
   assign w_skid_nxt = w_out_free ? (r_skid_vld && r_q_vld) : (r_skid_vld || r_q_vld);
   assign w_issue    = (r_state == READOUT) && (r_rd_cnt != c_depth) && !w_skid_nxt;

   rcv_buf_ram #(
      .WIDTH  (WIDTH),
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_ram (
      .clk     (clk),
      .i_we    (w_we),
      .i_waddr (r_wr_ptr),
      .i_wdata (in),
      .i_raddr (w_rd_addr),
      .o_rdata (w_q)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= IDLE;
         r_wr_ptr    <= '0;
         r_fill      <= '0;
         r_remaining <= '0;
         r_rd_cnt    <= '0;
         r_q_vld     <= 1'b0;
         r_q_last    <= 1'b0;
         r_skid_vld  <= 1'b0;
         r_skid_last <= 1'b0;
         r_skid_data <= '0;
         rd_data     <= '0;
         rd_valid    <= 1'b0;
         rd_last     <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
      end else begin
         done <= 1'b0;
         if (w_we)
            r_wr_ptr <= r_wr_ptr + c_ptr_one;

         case (r_state)
            IDLE: begin
               if (arm) begin
                  r_state  <= ARMED;
                  busy     <= 1'b1;
                  r_wr_ptr <= '0;
                  r_fill   <= '0;
                  r_rd_cnt <= '0;
               end
            end
            ARMED: begin
               if (clken && (r_fill != c_depth))
                  r_fill <= r_fill + c_cnt_one;
               if (w_accept) begin
                  r_remaining <= w_pc;
                  r_rd_cnt    <= '0;
                  r_state     <= (w_pc == '0) ? READOUT : POST;
               end
            end
            POST: begin
               if (clken) begin
                  r_remaining <= r_remaining - c_cnt_one;
                  if (r_remaining == c_cnt_one)
                     r_state <= READOUT;
               end
            end
            READOUT: begin
               if (w_issue)
                  r_rd_cnt <= r_rd_cnt + c_cnt_one;
               if (w_hs && rd_last) begin
                  r_state <= IDLE;
                  busy    <= 1'b0;
                  done    <= 1'b1;
               end
            end
            default: r_state <= IDLE;
         endcase

         r_q_vld  <= w_issue;
         r_q_last <= w_issue && (r_rd_cnt == (c_depth - c_cnt_one));

         // Output register drains the skid slot first, then the RAM stage.
         if (w_out_free) begin
            if (r_skid_vld) begin
               rd_valid <= 1'b1;
               rd_data  <= r_skid_data;
               rd_last  <= r_skid_last;
            end else begin
               rd_valid <= r_q_vld;
               rd_last  <= r_q_vld && r_q_last;
               if (r_q_vld)
                  rd_data <= w_q;
            end
         end
         r_skid_vld <= w_skid_nxt;
         if (r_q_vld && (r_skid_vld || !w_out_free)) begin
            r_skid_data <= w_q;
            r_skid_last <= r_q_last;
         end
      end
   end

endmodule
`default_nettype wire
